// File: rtl/uart_rx_cmd_ctrl_pkg.sv
// ============================================================================
//  Module : uart_rx_cmd_ctrl_pkg
//  Brief  : State encoding, default opcodes and config reset values.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_rx_cmd_ctrl_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_ADDR  = 3'd1;
    localparam logic [2:0] ST_WR_DATA  = 3'd2;
    localparam logic [2:0] ST_RD_ADDR  = 3'd3;
    localparam logic [2:0] ST_RD_WAIT  = 3'd4;
    localparam logic [2:0] ST_TX_WAIT  = 3'd5;
    localparam logic [2:0] ST_CFG_DATA = 3'd6;

    localparam logic [7:0] CMD_WR_DEF  = 8'hAA;
    localparam logic [7:0] CMD_RD_DEF  = 8'hBB;
    localparam logic [7:0] CMD_CFG_DEF = 8'hCC;

    localparam logic       PARITY_EN_RST   = 1'b1;
    localparam logic       PARITY_TYPE_RST = 1'b0;
    localparam logic [4:0] PRESCALE_RST    = 5'd8;

    // Only x8 and x16 oversampling are supported by the receiver.
    function automatic logic cfg_byte_ok(input logic [7:0] b);
        return !b[7] && ((b[6:2] == 5'd8) || (b[6:2] == 5'd16));
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_cmd_ctrl.sv
// ============================================================================
//  Module : uart_rx_cmd_ctrl
//  Brief  : UART byte-stream command decoder driving a register file,
//           the transmitter return path and the receiver configuration.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_cmd_ctrl
    import uart_rx_cmd_ctrl_pkg::*;
#(
    parameter int         ADDR_W  = 4,
    parameter logic [7:0] CMD_WR  = CMD_WR_DEF,
    parameter logic [7:0] CMD_RD  = CMD_RD_DEF,
    parameter logic [7:0] CMD_CFG = CMD_CFG_DEF
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [7:0]        P_Data,
    input  logic              Data_valid,
    input  logic              Parity_error,
    input  logic              stop_error,
    output logic              Parity_EN,
    output logic              Parity_type,
    output logic [4:0]        Prescale,
    output logic              WrEn,
    output logic              RdEn,
    output logic [ADDR_W-1:0] Address,
    output logic [7:0]        WrData,
    input  logic [7:0]        RdData,
    input  logic              RdData_valid,
    input  logic              Tx_busy,
    output logic [7:0]        Tx_P_Data,
    output logic              Tx_Data_valid,
    output logic [7:0]        Err_cnt
);

    logic [2:0] r_state;
    logic       w_rx_ok;
    logic       w_rx_bad;
    logic       w_addr_ok;
    logic       w_is_cmd;
    logic       w_err_inc;

    always_comb begin
        w_rx_ok   = Data_valid && !Parity_error && !stop_error;
        w_rx_bad  = Data_valid && (Parity_error || stop_error);
        w_addr_ok = ((P_Data >> ADDR_W) == 8'd0);
        w_is_cmd  = (P_Data == CMD_WR) || (P_Data == CMD_RD) || (P_Data == CMD_CFG);
        w_err_inc = 1'b0;
        case (r_state)
            ST_IDLE:     w_err_inc = w_rx_bad || (w_rx_ok && !w_is_cmd);
            ST_WR_ADDR,
            ST_RD_ADDR:  w_err_inc = w_rx_bad || (w_rx_ok && !w_addr_ok);
            ST_WR_DATA:  w_err_inc = w_rx_bad;
            ST_CFG_DATA: w_err_inc = w_rx_bad || (w_rx_ok && !cfg_byte_ok(P_Data));
            // Any byte arriving while a read is in flight is an overrun.
            ST_RD_WAIT,
            ST_TX_WAIT:  w_err_inc = Data_valid;
            default:     w_err_inc = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state       <= ST_IDLE;
            WrEn          <= 1'b0;
            RdEn          <= 1'b0;
            Tx_Data_valid <= 1'b0;
            Address       <= '0;
            WrData        <= 8'd0;
            Tx_P_Data     <= 8'd0;
            Err_cnt       <= 8'd0;
            Parity_EN     <= PARITY_EN_RST;
            Parity_type   <= PARITY_TYPE_RST;
            Prescale      <= PRESCALE_RST;
        end else begin
            WrEn          <= 1'b0;
            RdEn          <= 1'b0;
            Tx_Data_valid <= 1'b0;

            if (w_err_inc && (Err_cnt != 8'hFF))
                Err_cnt <= Err_cnt + 8'd1;

            case (r_state)
                ST_IDLE: begin
                    if (w_rx_ok) begin
                        if (P_Data == CMD_WR)
                            r_state <= ST_WR_ADDR;
                        else if (P_Data == CMD_RD)
                            r_state <= ST_RD_ADDR;
                        else if (P_Data == CMD_CFG)
                            r_state <= ST_CFG_DATA;
                    end
                end
                ST_WR_ADDR: begin
                    if (w_rx_ok && w_addr_ok) begin
                        Address <= P_Data[ADDR_W-1:0];
                        r_state <= ST_WR_DATA;
                    end else if (Data_valid) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WR_DATA: begin
                    if (w_rx_ok) begin
                        WrData <= P_Data;
                        WrEn   <= 1'b1;
                    end
                    if (Data_valid)
                        r_state <= ST_IDLE;
                end
                ST_RD_ADDR: begin
                    if (w_rx_ok && w_addr_ok) begin
                        Address <= P_Data[ADDR_W-1:0];
                        RdEn    <= 1'b1;
                        r_state <= ST_RD_WAIT;
                    end else if (Data_valid) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RD_WAIT: begin
                    if (RdData_valid) begin
                        Tx_P_Data <= RdData;
                        r_state   <= ST_TX_WAIT;
                    end
                end
                ST_TX_WAIT: begin
                    if (!Tx_busy) begin
                        Tx_Data_valid <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                ST_CFG_DATA: begin
                    if (w_rx_ok && cfg_byte_ok(P_Data)) begin
                        Parity_EN   <= P_Data[0];
                        Parity_type <= P_Data[1];
                        Prescale    <= P_Data[6:2];
                    end
                    if (Data_valid)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_cmd_ctrl.sv
// ============================================================================
//  Module : tb_uart_rx_cmd_ctrl
//  Brief  : Self-checking bench for uart_rx_cmd_ctrl.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_cmd_ctrl;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [7:0] P_Data;
    logic       Data_valid;
    logic       Parity_error;
    logic       stop_error;
    logic       Parity_EN;
    logic       Parity_type;
    logic [4:0] Prescale;
    logic       WrEn;
    logic       RdEn;
    logic [3:0] Address;
    logic [7:0] WrData;
    logic [7:0] RdData;
    logic       RdData_valid;
    logic       Tx_busy;
    logic [7:0] Tx_P_Data;
    logic       Tx_Data_valid;
    logic [7:0] Err_cnt;

    uart_rx_cmd_ctrl dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .P_Data        (P_Data),
        .Data_valid    (Data_valid),
        .Parity_error  (Parity_error),
        .stop_error    (stop_error),
        .Parity_EN     (Parity_EN),
        .Parity_type   (Parity_type),
        .Prescale      (Prescale),
        .WrEn          (WrEn),
        .RdEn          (RdEn),
        .Address       (Address),
        .WrData        (WrData),
        .RdData        (RdData),
        .RdData_valid  (RdData_valid),
        .Tx_busy       (Tx_busy),
        .Tx_P_Data     (Tx_P_Data),
        .Tx_Data_valid (Tx_Data_valid),
        .Err_cnt       (Err_cnt)
    );

    always #5 CLK = ~CLK;

    localparam logic [1:0] K_WR = 2'd0;
    localparam logic [1:0] K_RD = 2'd1;
    localparam logic [1:0] K_TX = 2'd2;

    typedef struct {
        logic [1:0] kind;
        logic [3:0] addr;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         n;
        int         bad_at;
        bit         bad_stop;
        bit         exp_wr;
        logic [3:0] exp_addr;
        logic [7:0] exp_data;
        int         err_inc;
        logic [6:0] exp_cfg;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[12];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_err  = 0;
    logic busy_at_edge = 1'b0;

    function automatic vec_t mk(input logic [7:0] b0, b1, b2, input int n, bad_at,
                                input bit bad_stop, exp_wr, input logic [3:0] a,
                                input logic [7:0] d, input int inc, input logic [6:0] cfg);
        vec_t v;
        v.b0 = b0; v.b1 = b1; v.b2 = b2; v.n = n; v.bad_at = bad_at;
        v.bad_stop = bad_stop; v.exp_wr = exp_wr; v.exp_addr = a; v.exp_data = d;
        v.err_inc = inc; v.exp_cfg = cfg;
        return v;
    endfunction

    function automatic int sat_add(input int e, input int inc);
        return (e + inc > 255) ? 255 : e + inc;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic pe, input logic se);
        @(posedge CLK); #1;
        P_Data = b; Data_valid = 1'b1; Parity_error = pe; stop_error = se;
        @(posedge CLK); #1;
        Data_valid = 1'b0; Parity_error = 1'b0; stop_error = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge CLK); #1; Reset = 1'b1;
        @(posedge CLK); #1; Reset = 1'b0;
        exp_err = 0;
    endtask

    task automatic wait_sb_empty(input int max_cyc, input string name);
        int i;
        for (i = 0; i < max_cyc && sb.size() != 0; i++) @(negedge CLK);
        check({name, "_timeout"}, sb.size(), 0);
    endtask

    task automatic check_status(input string name, input logic [6:0] cfg);
        @(negedge CLK);
        check({name, "_err"}, Err_cnt, exp_err);
        check({name, "_cfg"}, {Parity_EN, Parity_type, Prescale}, cfg);
    endtask

    always @(posedge CLK) busy_at_edge <= Tx_busy;

    // Scoreboard: every strobe must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (WrEn || RdEn || Tx_Data_valid) begin
            check("strobe_exclusive", int'(WrEn) + int'(RdEn) + int'(Tx_Data_valid), 1);
            if (Tx_Data_valid) check("tx_while_busy", busy_at_edge, 0);
            if (sb.size() == 0) begin
                check("unexpected_strobe", {WrEn, RdEn, Tx_Data_valid}, 0);
            end else begin
                e = sb.pop_front();
                if (WrEn) begin
                    check("wr_kind", K_WR, e.kind);
                    check("wr_addr", Address, e.addr);
                    check("wr_data", WrData, e.data);
                end else if (RdEn) begin
                    check("rd_kind", K_RD, e.kind);
                    check("rd_addr", Address, e.addr);
                end else begin
                    check("tx_kind", K_TX, e.kind);
                    check("tx_data", Tx_P_Data, e.data);
                end
            end
        end
    end

    localparam logic [6:0] CFG_DEF = {1'b1, 1'b0, 5'd8};

    initial begin
        exp_t e;
        int   k;
        Reset = 1'b1; P_Data = 8'h00; Data_valid = 1'b0; Parity_error = 1'b0;
        stop_error = 1'b0; RdData = 8'h00; RdData_valid = 1'b0; Tx_busy = 1'b0;

        vecs[0]  = mk(8'hAA, 8'h03, 8'h5C, 3, -1, 0, 1, 4'h3, 8'h5C, 0, CFG_DEF);
        vecs[1]  = mk(8'hAA, 8'h03, 8'h00, 2,  1, 0, 0, 4'h0, 8'h00, 1, CFG_DEF);
        vecs[2]  = mk(8'hAA, 8'h01, 8'hFF, 3, -1, 0, 1, 4'h1, 8'hFF, 0, CFG_DEF);
        vecs[3]  = mk(8'hAA, 8'h13, 8'h00, 2, -1, 0, 0, 4'h0, 8'h00, 1, CFG_DEF);
        vecs[4]  = mk(8'h5A, 8'h00, 8'h00, 1, -1, 0, 0, 4'h0, 8'h00, 1, CFG_DEF);
        vecs[5]  = mk(8'hCC, 8'h41, 8'h00, 2, -1, 0, 0, 4'h0, 8'h00, 0, {1'b1, 1'b0, 5'd16});
        vecs[6]  = mk(8'hCC, 8'h31, 8'h00, 2, -1, 0, 0, 4'h0, 8'h00, 1, {1'b1, 1'b0, 5'd16});
        vecs[7]  = mk(8'hCC, 8'h22, 8'h00, 2, -1, 0, 0, 4'h0, 8'h00, 0, {1'b0, 1'b1, 5'd8});
        vecs[8]  = mk(8'hCC, 8'hC1, 8'h00, 2, -1, 0, 0, 4'h0, 8'h00, 1, {1'b0, 1'b1, 5'd8});
        vecs[9]  = mk(8'hAA, 8'h0F, 8'h00, 3,  2, 1, 0, 4'h0, 8'h00, 1, {1'b0, 1'b1, 5'd8});
        vecs[10] = mk(8'hAA, 8'h0F, 8'h00, 3, -1, 0, 1, 4'hF, 8'h00, 0, {1'b0, 1'b1, 5'd8});
        vecs[11] = mk(8'hBB, 8'h25, 8'h00, 2, -1, 0, 0, 4'h0, 8'h00, 1, {1'b0, 1'b1, 5'd8});

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_wren", WrEn, 0);
        check("rst_rden", RdEn, 0);
        check("rst_txdv", Tx_Data_valid, 0);
        check("rst_addr", Address, 0);
        check("rst_wrdata", WrData, 0);
        check("rst_txdata", Tx_P_Data, 0);
        check("rst_err", Err_cnt, 0);
        check("rst_cfg", {Parity_EN, Parity_type, Prescale}, CFG_DEF);
        @(posedge CLK); #1; Reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].exp_wr) begin
                e.kind = K_WR; e.addr = vecs[i].exp_addr; e.data = vecs[i].exp_data;
                sb.push_back(e);
            end
            for (int j = 0; j < vecs[i].n; j++)
                send_byte((j == 0) ? vecs[i].b0 : (j == 1) ? vecs[i].b1 : vecs[i].b2,
                          (vecs[i].bad_at == j) && !vecs[i].bad_stop,
                          (vecs[i].bad_at == j) && vecs[i].bad_stop);
            exp_err = sat_add(exp_err, vecs[i].err_inc);
            repeat (3) @(posedge CLK);
            check_status($sformatf("vec%0d", i), vecs[i].exp_cfg);
            check($sformatf("vec%0d_sb", i), sb.size(), 0);
        end

        // Read with overrun during RD_WAIT and a busy transmitter.
        Tx_busy = 1'b1;
        e.kind = K_RD; e.addr = 4'h5; e.data = 8'h00; sb.push_back(e);
        e.kind = K_TX; e.addr = 4'h0; e.data = 8'hA7; sb.push_back(e);
        send_byte(8'hBB, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        for (k = 0; k < 20 && !RdEn; k++) @(negedge CLK);
        check("rden_seen", RdEn, 1);
        send_byte(8'h11, 1'b0, 1'b0);
        exp_err = sat_add(exp_err, 1);
        @(posedge CLK); #1; RdData = 8'hA7; RdData_valid = 1'b1;
        @(posedge CLK); #1; RdData_valid = 1'b0; RdData = 8'h00;
        repeat (10) @(posedge CLK);
        check("tx_held_busy", sb.size(), 1);
        #1; Tx_busy = 1'b0;
        wait_sb_empty(20, "tx_pulse");
        repeat (5) @(posedge CLK);
        check_status("read", {1'b0, 1'b1, 5'd8});

        // Reset in WR_DATA: a following data byte must not write.
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        pulse_reset();
        check_status("rst_wrdata", CFG_DEF);
        send_byte(8'h5C, 1'b0, 1'b0);
        exp_err = sat_add(exp_err, 1);
        repeat (3) @(posedge CLK);
        check_status("rst_wrdata_post", CFG_DEF);

        // Reset in RD_WAIT with non-default config.
        send_byte(8'hCC, 1'b0, 1'b0);
        send_byte(8'h41, 1'b0, 1'b0);
        e.kind = K_RD; e.addr = 4'h4; e.data = 8'h00; sb.push_back(e);
        send_byte(8'hBB, 1'b0, 1'b0);
        send_byte(8'h04, 1'b0, 1'b0);
        wait_sb_empty(20, "rd_rst");
        pulse_reset();
        @(posedge CLK); #1; RdData = 8'h55; RdData_valid = 1'b1;
        @(posedge CLK); #1; RdData_valid = 1'b0;
        repeat (5) @(posedge CLK);
        check_status("rst_rdwait", CFG_DEF);

        // Error counter saturation.
        send_byte(8'h5A, 1'b0, 1'b0);
        exp_err = sat_add(exp_err, 1);
        for (int i = 0; i < 300; i++) begin
            send_byte(8'hAA, 1'b0, 1'b1);
            exp_err = sat_add(exp_err, 1);
            if (i == 199) begin
                @(negedge CLK);
                check("err_mid", Err_cnt, exp_err);
            end
        end
        @(negedge CLK);
        check("err_sat", Err_cnt, 8'hFF);
        check("err_model", exp_err, 255);
        check_status("final", CFG_DEF);

        repeat (5) @(posedge CLK);
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
